// File: rtl/mem_read_pkg.sv
// Shared types and constants for the memory read streamer and its 8 x 32 memory stage.
// Contents: state enum for the streamer FSM, default widths, and memory geometry constants.
package mem_read_pkg;

  localparam int unsigned AddrWDefault = 32;
  localparam int unsigned DataWDefault = 32;
  localparam int unsigned LenWDefault  = 4;

  // Memory stage geometry; the stage truncates io_addr to its low MEM_IDX_W bits.
  localparam int unsigned MEM_DEPTH = 8;
  localparam int unsigned MEM_IDX_W = 3;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StStream = 1'b1
  } state_e;

endpackage

// File: rtl/mem_read_resp_slot.sv
// One-entry registered response slot holding {data, last} with valid/ready handshake.
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   load_i              capture data_i/last_i this cycle (caller guarantees slot is free or draining)
//   data_i, last_i      beat to capture
//   ready_i             consumer accepts the held beat
//   valid_o             slot holds a beat
//   data_o, last_o      held beat, stable while valid_o && !ready_i
module mem_read_resp_slot #(
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DataW-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic             last_o
);

  logic             valid_q, valid_d;
  logic [DataW-1:0] data_q, data_d;
  logic             last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      // A load in the same cycle as a drain keeps the slot full with the new beat.
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/mem_read_streamer.sv
// Burst read address sequencer for the asynchronous-read memory stage.
// Accepts {base, len} bursts, drives one read address per cycle and captures the combinational
// read data into a one-entry response slot with backpressure.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   io_req_valid/ready/base/len      burst request handshake
//   io_mem_addr, io_mem_data         registered read address out, combinational read data in
//   io_resp_valid/ready/data/last    response beat handshake
//   io_busy                          streaming or response slot occupied
//   io_beat_count                    saturating response handshake count
//                                    (only when MEM_READ_STREAMER_STATS_EN is defined)
module mem_read_streamer
  import mem_read_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned LEN_W  = LenWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [ADDR_W-1:0] io_req_base,
  input  logic [LEN_W-1:0]  io_req_len,
  output logic [ADDR_W-1:0] io_mem_addr,
  input  logic [DATA_W-1:0] io_mem_data,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [DATA_W-1:0] io_resp_data,
  output logic              io_resp_last,
  output logic              io_busy
`ifdef MEM_READ_STREAMER_STATS_EN
  ,
  output logic [15:0]       io_beat_count
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              load;
  logic              last_beat;
  logic              req_ready;

  // Ready depends on registers only, so it never forms a path from io_req_valid.
  assign req_ready = (state_q == StIdle) && !io_resp_valid;
  assign last_beat = (rem_q == LEN_W'(1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A zero-length request completes its handshake with no effect.
        if (io_req_valid && req_ready && (io_req_len != '0)) begin
          addr_d  = io_req_base;
          rem_d   = io_req_len;
          state_d = StStream;
        end
      end
      StStream: begin
        if (!io_resp_valid || io_resp_ready) begin
          load   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (last_beat) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  mem_read_resp_slot #(
    .DataW (DATA_W)
  ) u_resp_slot (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (load),
    .data_i  (io_mem_data),
    .last_i  (last_beat),
    .ready_i (io_resp_ready),
    .valid_o (io_resp_valid),
    .data_o  (io_resp_data),
    .last_o  (io_resp_last)
  );

  assign io_req_ready = req_ready;
  assign io_mem_addr  = addr_q;
  assign io_busy      = (state_q == StStream) || io_resp_valid;

`ifdef MEM_READ_STREAMER_STATS_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (io_resp_valid && io_resp_ready && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign io_beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_mem_read_streamer.sv
module tb_mem_read_streamer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_base;
  logic [3:0]  req_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_last;
  logic        busy;
`ifdef MEM_READ_STREAMER_STATS_EN
  logic [15:0] beat_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [8];
  assign mem_data = mem[mem_addr[2:0]];

  mem_read_streamer dut (
    .clk           (clk),
    .reset         (reset),
    .io_req_valid  (req_valid),
    .io_req_ready  (req_ready),
    .io_req_base   (req_base),
    .io_req_len    (req_len),
    .io_mem_addr   (mem_addr),
    .io_mem_data   (mem_data),
    .io_resp_valid (resp_valid),
    .io_resp_ready (resp_ready),
    .io_resp_data  (resp_data),
    .io_resp_last  (resp_last),
    .io_busy       (busy)
`ifdef MEM_READ_STREAMER_STATS_EN
    ,
    .io_beat_count (beat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] base;
    logic [3:0]  len;
    logic        rr;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_d;
    logic        e_l;
    logic [31:0] e_a;
    logic        e_busy;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input logic [31:0] b, input logic [3:0] l);
    int t;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_base   = b;
    req_len    = l;
    step();
    req_valid = 1'b0;
    t = 0;
    while (busy && t < 40) begin
      step();
      t++;
    end
    check("burst_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] bp_exp [3];
    int k;

    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
    reset = 1'b1; req_valid = 1'b0; req_base = '0; req_len = '0; resp_ready = 1'b1;

    //            rst   rv    base   len   rr    rdy   v     data        l     addr   busy
    vecs[0]  = '{1'b1, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 32'd0,  1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 32'd0,  1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'd2, 4'd4, 1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'd2,  1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'd5, 4'd7, 1'b1, 1'b0, 1'b1, 32'h102,   1'b0, 32'd3,  1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h103,   1'b0, 32'd4,  1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h104,   1'b0, 32'd5,  1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h105,   1'b1, 32'd6,  1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h105,   1'b1, 32'd6,  1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'd6, 4'd4, 1'b1, 1'b0, 1'b0, 32'h105,   1'b1, 32'd6,  1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h106,   1'b0, 32'd7,  1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h107,   1'b0, 32'd8,  1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h100,   1'b0, 32'd9,  1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h101,   1'b1, 32'd10, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h101,   1'b1, 32'd10, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'd3, 4'd0, 1'b1, 1'b1, 1'b0, 32'h101,   1'b1, 32'd10, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h101,   1'b1, 32'd10, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 32'd0, 4'd1, 1'b1, 1'b0, 1'b0, 32'h101,   1'b1, 32'd0,  1'b1};
    vecs[17] = '{1'b0, 1'b1, 32'd4, 4'd2, 1'b1, 1'b0, 1'b1, 32'h100,   1'b1, 32'd1,  1'b1};
    vecs[18] = '{1'b0, 1'b1, 32'd4, 4'd2, 1'b0, 1'b0, 1'b1, 32'h100,   1'b1, 32'd1,  1'b1};
    vecs[19] = '{1'b0, 1'b1, 32'd4, 4'd2, 1'b1, 1'b1, 1'b0, 32'h100,   1'b1, 32'd1,  1'b0};
    vecs[20] = '{1'b0, 1'b1, 32'd4, 4'd2, 1'b1, 1'b0, 1'b0, 32'h100,   1'b1, 32'd4,  1'b1};
    vecs[21] = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h104,   1'b0, 32'd5,  1'b1};
    vecs[22] = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h105,   1'b1, 32'd6,  1'b1};
    vecs[23] = '{1'b0, 1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h105,   1'b1, 32'd6,  1'b0};

    for (int i = 0; i < 24; i++) begin
      reset      = vecs[i].rst;
      req_valid  = vecs[i].rv;
      req_base   = vecs[i].base;
      req_len    = vecs[i].len;
      resp_ready = vecs[i].rr;
      step();
      check($sformatf("v%0d.req_ready", i), {31'b0, req_ready}, {31'b0, vecs[i].e_rdy});
      check($sformatf("v%0d.resp_valid", i), {31'b0, resp_valid}, {31'b0, vecs[i].e_v});
      check($sformatf("v%0d.resp_data", i), resp_data, vecs[i].e_d);
      check($sformatf("v%0d.resp_last", i), {31'b0, resp_last}, {31'b0, vecs[i].e_l});
      check($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_a);
      check($sformatf("v%0d.busy", i), {31'b0, busy}, {31'b0, vecs[i].e_busy});
    end

    // Backpressure: base 0, len 3, consumer stalls for 3 cycles once the first beat is held.
    bp_exp[0] = 32'h100; bp_exp[1] = 32'h101; bp_exp[2] = 32'h102;
    resp_ready = 1'b0; req_valid = 1'b1; req_base = 32'd0; req_len = 4'd3;
    step();
    req_valid = 1'b0;
    check("bp.addr_base", mem_addr, 32'd0);
    step();
    check("bp.first_valid", {31'b0, resp_valid}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("bp.hold%0d.valid", c), {31'b0, resp_valid}, 32'd1);
      check($sformatf("bp.hold%0d.data", c), resp_data, 32'h100);
      check($sformatf("bp.hold%0d.last", c), {31'b0, resp_last}, 32'd0);
      check($sformatf("bp.hold%0d.addr", c), mem_addr, 32'd1);
    end
    resp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10 && k < 3; c++) begin
      if (resp_valid) begin
        check($sformatf("bp.beat%0d.data", k), resp_data, bp_exp[k]);
        check($sformatf("bp.beat%0d.last", k), {31'b0, resp_last}, (k == 2) ? 32'd1 : 32'd0);
        k++;
      end
      step();
    end
    check("bp.beat_total", k, 32'd3);
    check("bp.no_extra", {31'b0, resp_valid}, 32'd0);
    check("bp.idle_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of an 8-beat burst after two beats.
    req_valid = 1'b1; req_base = 32'd0; req_len = 4'd8;
    step();
    req_valid = 1'b0;
    step();
    check("rst.beat0", resp_data, 32'h100);
    step();
    check("rst.beat1", resp_data, 32'h101);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst.valid", {31'b0, resp_valid}, 32'd0);
    check("rst.req_ready", {31'b0, req_ready}, 32'd1);
    check("rst.addr", mem_addr, 32'd0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.data", resp_data, 32'd0);
    step();
    check("rst.after.valid", {31'b0, resp_valid}, 32'd0);
    check("rst.after.addr", mem_addr, 32'd0);

`ifdef MEM_READ_STREAMER_STATS_EN
    check("stats.reset", {16'b0, beat_count}, 32'd0);
    run_burst(32'd0, 4'd5);
    run_burst(32'd3, 4'd3);
    check("stats.count8", {16'b0, beat_count}, 32'd8);
    force dut.beat_cnt_q = 16'hFFFF;
    #1;
    release dut.beat_cnt_q;
    run_burst(32'd0, 4'd1);
    check("stats.saturate", {16'b0, beat_count}, 32'h0000_FFFF);
`else
    run_burst(32'd7, 4'd2);
    check("final.addr", mem_addr, 32'd9);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
